// File: rtl/rom_arbiter.sv
// rom_arbiter: shares one combinational ROM read port between instruction
// fetch and data load. Fetch wins ties, a saturating starvation counter
// forces a waiting load through, and faulting addresses return err with
// zero data instead of ROM contents.
//
// Handshake: a requester raises *_req with a stable *_addr and holds both
// until it sees *_gnt high in the same cycle; the grant is combinational.
// Nothing is buffered, so an ungranted request is re-arbitrated every cycle.
// The response (*_rvalid, *_rdata, *_err) is registered and appears exactly
// one cycle after the grant, as a single-cycle rvalid pulse.
module rom_arbiter #(
  parameter int ADDR_W     = 12,
  parameter int DATA_W     = 32,
  parameter int ROM_WORDS  = 128,
  parameter int STARVE_MAX = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic              if_gnt,
  output logic              if_rvalid,
  output logic [DATA_W-1:0] if_rdata,
  output logic              if_err,
  input  logic              ld_req,
  input  logic [ADDR_W-1:0] ld_addr,
  output logic              ld_gnt,
  output logic              ld_rvalid,
  output logic [DATA_W-1:0] ld_rdata,
  output logic              ld_err,
  output logic [ADDR_W-1:0] rom_addr,
  input  logic [DATA_W-1:0] rom_inst
);

  localparam int CNT_W    = $clog2(STARVE_MAX + 1);
  localparam int ROM_SIZE = 4 * ROM_WORDS;
  localparam logic [ADDR_W:0]  ROM_BYTES = (ADDR_W + 1)'(ROM_SIZE);
  localparam logic [CNT_W-1:0] CNT_MAX   = CNT_W'(STARVE_MAX);

  logic [CNT_W-1:0] starve_cnt;
  logic             force_ld;
  logic             if_fault;
  logic             ld_fault;

  // A fault is either past the end of the ROM or not word aligned; the
  // extra top bit keeps the range compare safe when the ROM fills ADDR_W.
  assign if_fault = ({1'b0, if_addr} >= ROM_BYTES) || (if_addr[1:0] != 2'b00);
  assign ld_fault = ({1'b0, ld_addr} >= ROM_BYTES) || (ld_addr[1:0] != 2'b00);

  // A load that has been denied STARVE_MAX times in a row beats fetch.
  assign force_ld = ld_req && (starve_cnt == CNT_MAX);

  // Grant selection and ROM address mux; reset suppresses all grants.
  always_comb begin
    if_gnt   = 1'b0;
    ld_gnt   = 1'b0;
    rom_addr = '0;
    if (!reset) begin
      if (force_ld) begin
        ld_gnt   = 1'b1;
        rom_addr = ld_addr;
      end else if (if_req) begin
        if_gnt   = 1'b1;
        rom_addr = if_addr;
      end else if (ld_req) begin
        ld_gnt   = 1'b1;
        rom_addr = ld_addr;
      end
    end
  end

  // Starvation counter: counts consecutive denied load cycles, saturating.
  always_ff @(posedge clk) begin
    if (reset) begin
      starve_cnt <= '0;
    end else if (ld_gnt || !ld_req) begin
      starve_cnt <= '0;
    end else if (starve_cnt != CNT_MAX) begin
      starve_cnt <= starve_cnt + 1'b1;
    end
  end

  // Fetch response: capture ROM data on grant; rdata/err hold otherwise.
  always_ff @(posedge clk) begin
    if (reset) begin
      if_rvalid <= 1'b0;
      if_rdata  <= '0;
      if_err    <= 1'b0;
    end else begin
      if_rvalid <= if_gnt;
      if (if_gnt) begin
        if_rdata <= if_fault ? '0 : rom_inst;
        if_err   <= if_fault;
      end
    end
  end

  // Load response: same capture rule as fetch, on the load grant.
  always_ff @(posedge clk) begin
    if (reset) begin
      ld_rvalid <= 1'b0;
      ld_rdata  <= '0;
      ld_err    <= 1'b0;
    end else begin
      ld_rvalid <= ld_gnt;
      if (ld_gnt) begin
        ld_rdata <= ld_fault ? '0 : rom_inst;
        ld_err   <= ld_fault;
      end
    end
  end

endmodule

// File: tb/tb_rom_arbiter.sv
// tb_rom_arbiter: directed scenarios for rom_arbiter with a small ROM model.
// ROM word i reads as 32'hC0DE_0000 | i; addresses past the ROM read as
// 32'hDEAD_BEEF so a fault that leaks ROM data shows up.
module tb_rom_arbiter;

  localparam int ADDR_W = 12;
  localparam int DATA_W = 32;

  logic              clk = 1'b0;
  logic              reset;
  logic              if_req;
  logic [ADDR_W-1:0] if_addr;
  logic              if_gnt;
  logic              if_rvalid;
  logic [DATA_W-1:0] if_rdata;
  logic              if_err;
  logic              ld_req;
  logic [ADDR_W-1:0] ld_addr;
  logic              ld_gnt;
  logic              ld_rvalid;
  logic [DATA_W-1:0] ld_rdata;
  logic              ld_err;
  logic [ADDR_W-1:0] rom_addr;
  logic [DATA_W-1:0] rom_inst;

  int checks   = 0;
  int failures = 0;

  // Clock / ROM model
  always #5 clk = ~clk;

  assign rom_inst = (rom_addr < 12'h200) ? (32'hC0DE_0000 | {25'd0, rom_addr[8:2]})
                                         : 32'hDEAD_BEEF;

  rom_arbiter #(
    .ADDR_W(ADDR_W), .DATA_W(DATA_W), .ROM_WORDS(128), .STARVE_MAX(4)
  ) dut (
    .clk(clk), .reset(reset),
    .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt),
    .if_rvalid(if_rvalid), .if_rdata(if_rdata), .if_err(if_err),
    .ld_req(ld_req), .ld_addr(ld_addr), .ld_gnt(ld_gnt),
    .ld_rvalid(ld_rvalid), .ld_rdata(ld_rdata), .ld_err(ld_err),
    .rom_addr(rom_addr), .rom_inst(rom_inst)
  );

  // Driver tasks: inputs change 1 time unit after the rising edge;
  // combinational outputs are sampled at the falling edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic mid();
    @(negedge clk);
  endtask

  task automatic test_reset();
    reset   = 1'b1;
    if_req  = 1'b1;
    if_addr = 12'h004;
    ld_req  = 1'b1;
    ld_addr = 12'h008;
    tick();
    tick();
    mid();
    checks++;
    if ({if_gnt, ld_gnt, rom_addr} !== {1'b0, 1'b0, 12'h000}) begin
      failures++;
      $display("FAIL reset_gnt got gnt=%b%b rom_addr=%h exp 00 000", if_gnt, ld_gnt, rom_addr);
    end
    checks++;
    if ({if_rvalid, ld_rvalid, if_err, ld_err, if_rdata, ld_rdata} !== 68'd0) begin
      failures++;
      $display("FAIL reset_resp got rv=%b%b err=%b%b if_rdata=%h ld_rdata=%h exp all 0",
               if_rvalid, ld_rvalid, if_err, ld_err, if_rdata, ld_rdata);
    end
    tick();
    reset  = 1'b0;
    if_req = 1'b0;
    ld_req = 1'b0;
    tick();
  endtask

  task automatic test_fetch_only();
    logic [ADDR_W-1:0] a;
    if_req = 1'b1;
    for (int k = 0; k < 3; k++) begin
      a = ADDR_W'(4 * k);
      if_addr = a;
      mid();
      checks++;
      if ({if_gnt, ld_gnt, rom_addr} !== {1'b1, 1'b0, a}) begin
        failures++;
        $display("FAIL fetch_gnt[%0d] got gnt=%b%b rom_addr=%h exp 10 %h", k, if_gnt, ld_gnt, rom_addr, a);
      end
      tick();
      checks++;
      if ({if_rvalid, if_err, if_rdata} !== {1'b1, 1'b0, 32'hC0DE_0000 | k}) begin
        failures++;
        $display("FAIL fetch_resp[%0d] got rv=%b err=%b rdata=%h exp 1 0 %h",
                 k, if_rvalid, if_err, if_rdata, 32'hC0DE_0000 | k);
      end
      checks++;
      if ({ld_rvalid, ld_err, ld_rdata} !== 34'd0) begin
        failures++;
        $display("FAIL fetch_ld_quiet[%0d] got rv=%b err=%b rdata=%h exp 0 0 0", k, ld_rvalid, ld_err, ld_rdata);
      end
    end
    if_req = 1'b0;
    tick();
    checks++;
    if (if_rvalid !== 1'b0) begin
      failures++;
      $display("FAIL fetch_rvalid_drop got %b exp 0", if_rvalid);
    end
  endtask

  // Fetch hogs the port; load at 0x010 must win in cycle 4 (STARVE_MAX=4).
  task automatic test_contention(input string tag);
    logic exp_ld;
    if_req  = 1'b1;
    if_addr = 12'h020;
    ld_req  = 1'b1;
    ld_addr = 12'h010;
    for (int c = 0; c < 6; c++) begin
      exp_ld = (c == 4);
      mid();
      checks++;
      if ({if_gnt, ld_gnt, rom_addr} !== {~exp_ld, exp_ld, exp_ld ? 12'h010 : 12'h020}) begin
        failures++;
        $display("FAIL %s_gnt[c%0d] got gnt=%b%b rom_addr=%h exp %b%b %h", tag, c,
                 if_gnt, ld_gnt, rom_addr, ~exp_ld, exp_ld, exp_ld ? 12'h010 : 12'h020);
      end
      tick();
      if (exp_ld) ld_req = 1'b0;
      checks++;
      if ({if_rvalid, ld_rvalid} !== {~exp_ld, exp_ld}) begin
        failures++;
        $display("FAIL %s_rvalid[c%0d] got %b%b exp %b%b", tag, c, if_rvalid, ld_rvalid, ~exp_ld, exp_ld);
      end
      if (exp_ld) begin
        checks++;
        if ({ld_err, ld_rdata} !== {1'b0, 32'hC0DE_0004}) begin
          failures++;
          $display("FAIL %s_ld_data got err=%b rdata=%h exp 0 c0de0004", tag, ld_err, ld_rdata);
        end
      end
    end
    if_req = 1'b0;
    tick();
  endtask

  task automatic test_simultaneous();
    if_req  = 1'b1;
    if_addr = 12'h00C;
    ld_req  = 1'b1;
    ld_addr = 12'h018;
    mid();
    checks++;
    if ({if_gnt, ld_gnt, rom_addr} !== {1'b1, 1'b0, 12'h00C}) begin
      failures++;
      $display("FAIL simul_first got gnt=%b%b rom_addr=%h exp 10 00c", if_gnt, ld_gnt, rom_addr);
    end
    tick();
    if_req = 1'b0;
    checks++;
    if ({if_rvalid, if_rdata} !== {1'b1, 32'hC0DE_0003}) begin
      failures++;
      $display("FAIL simul_if_resp got rv=%b rdata=%h exp 1 c0de0003", if_rvalid, if_rdata);
    end
    mid();
    checks++;
    if ({if_gnt, ld_gnt, rom_addr} !== {1'b0, 1'b1, 12'h018}) begin
      failures++;
      $display("FAIL simul_second got gnt=%b%b rom_addr=%h exp 01 018", if_gnt, ld_gnt, rom_addr);
    end
    tick();
    ld_req = 1'b0;
    checks++;
    if ({ld_rvalid, ld_rdata, if_rvalid, if_rdata} !== {1'b1, 32'hC0DE_0006, 1'b0, 32'hC0DE_0003}) begin
      failures++;
      $display("FAIL simul_ld_resp got ld rv=%b rdata=%h if rv=%b rdata=%h exp 1 c0de0006 0 c0de0003",
               ld_rvalid, ld_rdata, if_rvalid, if_rdata);
    end
    tick();
  endtask

  // Back-to-back loads: two faults then the last ROM word.
  task automatic test_faults();
    logic [ADDR_W-1:0] addr_v [3] = '{12'h200, 12'h006, 12'h1FC};
    logic              err_v  [3] = '{1'b1, 1'b1, 1'b0};
    logic [DATA_W-1:0] data_v [3] = '{32'h0, 32'h0, 32'hC0DE_007F};
    ld_req = 1'b1;
    for (int k = 0; k < 3; k++) begin
      ld_addr = addr_v[k];
      mid();
      checks++;
      if ({ld_gnt, rom_addr} !== {1'b1, addr_v[k]}) begin
        failures++;
        $display("FAIL fault_gnt[%0d] got gnt=%b rom_addr=%h exp 1 %h", k, ld_gnt, rom_addr, addr_v[k]);
      end
      tick();
      checks++;
      if ({ld_rvalid, ld_err, ld_rdata} !== {1'b1, err_v[k], data_v[k]}) begin
        failures++;
        $display("FAIL fault_resp[%0d] got rv=%b err=%b rdata=%h exp 1 %b %h",
                 k, ld_rvalid, ld_err, ld_rdata, err_v[k], data_v[k]);
      end
    end
    ld_req  = 1'b0;
    if_req  = 1'b1;
    if_addr = 12'h3FF;
    tick();
    if_req = 1'b0;
    checks++;
    if ({if_rvalid, if_err, if_rdata} !== {1'b1, 1'b1, 32'h0}) begin
      failures++;
      $display("FAIL fault_fetch got rv=%b err=%b rdata=%h exp 1 1 0", if_rvalid, if_err, if_rdata);
    end
    tick();
  endtask

  // Build up starvation, reset in a fetch-grant cycle, then re-run contention.
  task automatic test_reset_mid();
    if_req  = 1'b1;
    if_addr = 12'h020;
    ld_req  = 1'b1;
    ld_addr = 12'h010;
    tick();
    tick();
    mid();
    checks++;
    if (if_gnt !== 1'b1) begin
      failures++;
      $display("FAIL rstmid_pre_gnt got %b exp 1", if_gnt);
    end
    reset = 1'b1;
    #1;
    checks++;
    if ({if_gnt, ld_gnt, rom_addr} !== {1'b0, 1'b0, 12'h000}) begin
      failures++;
      $display("FAIL rstmid_gnt got gnt=%b%b rom_addr=%h exp 00 000", if_gnt, ld_gnt, rom_addr);
    end
    tick();
    checks++;
    if ({if_rvalid, ld_rvalid, if_rdata, ld_rdata} !== 66'd0) begin
      failures++;
      $display("FAIL rstmid_resp got rv=%b%b if_rdata=%h ld_rdata=%h exp 00 0 0",
               if_rvalid, ld_rvalid, if_rdata, ld_rdata);
    end
    reset = 1'b0;
    test_contention("rerun");
  endtask

  task automatic test_idle();
    if_req = 1'b0;
    ld_req = 1'b0;
    for (int c = 0; c < 4; c++) begin
      mid();
      checks++;
      if ({if_gnt, ld_gnt, rom_addr} !== {1'b0, 1'b0, 12'h000}) begin
        failures++;
        $display("FAIL idle_gnt[%0d] got gnt=%b%b rom_addr=%h exp 00 000", c, if_gnt, ld_gnt, rom_addr);
      end
      tick();
      checks++;
      if ({if_rvalid, ld_rvalid} !== 2'b00) begin
        failures++;
        $display("FAIL idle_rvalid[%0d] got %b%b exp 00", c, if_rvalid, ld_rvalid);
      end
    end
  endtask

  // Sequence and final report
  initial begin
    test_reset();
    test_fetch_only();
    test_contention("contend");
    test_idle();
    test_simultaneous();
    test_faults();
    test_reset_mid();
    test_idle();
    test_simultaneous();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/rom_arbiter.md
# rom_arbiter

Two-port arbiter that shares the single combinational read port of the 128-word boot/instruction ROM between the core's instruction-fetch path and its data-load path, for loads of constants and tables out of ROM space. It sits between the core and the ROM. Each port gets a request/grant handshake and a registered read response one cycle after the grant. Fetch has priority, and a starvation counter bounds how long a load can wait. Out-of-range and misaligned load addresses are flagged instead of returning undefined ROM contents.

## Interface
- ADDR_W, 12, byte-address width of both ports and of the ROM address
- DATA_W, 32, word width
- ROM_WORDS, 128, ROM depth in words; valid byte range is 0 to 4*ROM_WORDS-1
- STARVE_MAX, 4, number of consecutive denied load cycles after which the load is forced through

Ports:
- clk, input, 1, system clock; all state updates on the rising edge
- reset, input, 1, synchronous, active-high reset
- if_req, input, 1, fetch request; held with if_addr stable until if_gnt
- if_addr, input, ADDR_W, fetch byte address
- if_gnt, output, 1, fetch granted this cycle (combinational)
- if_rvalid, output, 1, fetch response valid (registered)
- if_rdata, output, DATA_W, fetch response word
- if_err, output, 1, fetch address fault; qualified by if_rvalid
- ld_req, input, 1, load request; same hold rules as if_req
- ld_addr, input, ADDR_W, load byte address
- ld_gnt, output, 1, load granted this cycle
- ld_rvalid, output, 1, load response valid
- ld_rdata, output, DATA_W, load response word
- ld_err, output, 1, load address fault; qualified by ld_rvalid
- rom_addr, output, ADDR_W, address driven to the ROM
- rom_inst, input, DATA_W, ROM read data, combinational from rom_addr

## Operation
- At most one grant per cycle. if_gnt and ld_gnt are never both 1.
- Grant rule, in order:
  - If ld_req is high and starve_cnt is STARVE_MAX, grant the load.
  - Otherwise, if if_req is high, grant the fetch.
  - Otherwise, if ld_req is high, grant the load.
  - Otherwise, no grant.
- starve_cnt is a saturating counter, width clog2(STARVE_MAX+1).
  - It increments on each cycle where ld_req is high and ld_gnt is low.
  - It clears on ld_gnt, or on any cycle where ld_req is low.
- rom_addr carries the granted port's address. With no grant, rom_addr is 0.
- On a grant, the arbiter captures rom_inst into the granted port's rdata register and raises that port's rvalid for exactly one cycle.
- The other port's rdata register holds its previous value.
- Address fault, for either port: addr ≥ 4*ROM_WORDS (out of range) or addr[1:0] ≠ 0 (misaligned).
  - On a fault: rdata is 0, err is 1, and the access still consumes its grant.
  - Without a fault: err is 0.
- Requesters can issue back-to-back requests. A new request can be granted in the same cycle the previous response is valid.
- No buffering of unaccepted requests. The requester holds the request and the arbiter re-arbitrates every cycle.

## Timing
- Grant is combinational in cycle N from the req inputs and starve_cnt. The response (rvalid, rdata, err) is registered and valid in cycle N+1.
- Latency from request to response is 1 cycle when uncontended.
- Worst-case load wait while fetch requests every cycle is STARVE_MAX cycles; the grant comes in the (STARVE_MAX+1)-th cycle of the request.
- A fetch request denied by a forced load is granted next cycle, because starve_cnt clears on the load grant.
- Reset, including assertion mid-transaction:
  - Outputs: if_rvalid, ld_rvalid, if_err and ld_err are 0; if_rdata and ld_rdata are 0.
  - Internal state: starve_cnt is 0.
  - A response pending for the cycle after reset is dropped.
  - Grants are suppressed while reset is high, so rom_addr is 0 and both gnt outputs are 0.
- Requests are sampled again from the first cycle after reset deasserts.

## Test plan
- Fetch only: if_req held high; if_addr = 0x000, then 0x004, then 0x008 on consecutive cycles.
  - Required: if_gnt high every cycle; if_rvalid high from the next cycle with if_rdata = rom[0], rom[1], rom[2]; ld_* outputs stay 0.
- Contention with STARVE_MAX=4: if_req constantly high, ld_req rises at cycle 0 with ld_addr = 0x010.
  - Required: if_gnt high in cycles 0–3; ld_gnt high in cycle 4 with rom_addr = 0x010; ld_rvalid in cycle 5 with ld_rdata = rom[4]; if_gnt high again in cycle 5.
- Simultaneous requests with starve_cnt at 0: both ports request in the same cycle.
  - Required: fetch granted first; load granted in the next cycle once if_req drops.
- Faults: ld_addr = 0x200 (out of range), then ld_addr = 0x006 (misaligned).
  - Required: ld_rvalid with ld_err = 1 and ld_rdata = 0 for both; ld_addr = 0x1FC returns rom[127] with ld_err = 0.
- Reset mid-operation: assert reset in the cycle of if_gnt.
  - Required: in the next cycle if_rvalid = 0 and both rdata outputs are 0; starve_cnt is 0, checked by rerunning the contention scenario after reset and seeing the same cycle-4 load grant.
- Idle: no requests.
  - Required: rom_addr = 0; both gnt and rvalid outputs stay 0; starve_cnt stays 0.
